// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake and payload bundle for the memory stage.
// Also carries the synchronous SRAM read data and the ID forwarding path.
interface mem_stage_if;
  logic         ex_to_mem_valid;
  logic [138:0] ex_to_mem_bus;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;

  modport master (
    output ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: latches EX payload, aligns/extends load data, and
// holds the SRAM word while WB stalls, because the SRAM only presents it for one cycle.
module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave mem_if
);
  typedef enum logic {FRESH = 1'b0, HELD = 1'b1} data_state_e;

  logic        mem_valid_q, mem_valid_d;
  logic [31:0] pc_q, pc_d;
  logic        res_from_mem_q, res_from_mem_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  ld_type_q, ld_type_d;
  logic [31:0] hold_q, hold_d;
  data_state_e state_q, state_d;

  logic mem_allowin, entry;
  assign mem_allowin = ~mem_valid_q | mem_if.wb_allowin;
  assign entry       = mem_if.ex_to_mem_valid & mem_allowin;

  // Store data, upper address bits and the store flag of ld_st_type play no part here.
  logic unused_bits;
  assign unused_bits = ^{mem_if.ex_to_mem_bus[67:36], mem_if.ex_to_mem_bus[35:6],
                         mem_if.ex_to_mem_bus[3]};

  always_comb begin
    mem_valid_d    = mem_valid_q;
    pc_d           = pc_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    addr_lo_d      = addr_lo_q;
    ld_type_d      = ld_type_q;
    if (mem_allowin) mem_valid_d = mem_if.ex_to_mem_valid;
    if (entry) begin
      pc_d           = mem_if.ex_to_mem_bus[138:107];
      res_from_mem_d = mem_if.ex_to_mem_bus[106];
      rf_we_d        = mem_if.ex_to_mem_bus[105];
      rf_waddr_d     = mem_if.ex_to_mem_bus[104:100];
      alu_result_d   = mem_if.ex_to_mem_bus[99:68];
      addr_lo_d      = mem_if.ex_to_mem_bus[5:4];
      ld_type_d      = mem_if.ex_to_mem_bus[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (entry) begin
      state_d = FRESH;
    end else begin
      unique case (state_q)
        FRESH: if (mem_valid_q & res_from_mem_q & ~mem_if.wb_allowin) begin
          hold_d  = mem_if.data_sram_rdata;
          state_d = HELD;
        end
        HELD: if (mem_valid_q & mem_if.wb_allowin) state_d = FRESH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      addr_lo_q      <= '0;
      ld_type_q      <= '0;
      hold_q         <= '0;
      state_q        <= FRESH;
    end else begin
      mem_valid_q    <= mem_valid_d;
      pc_q           <= pc_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      addr_lo_q      <= addr_lo_d;
      ld_type_q      <= ld_type_d;
      hold_q         <= hold_d;
      state_q        <= state_d;
    end
  end

  logic [31:0] raw, ld_data, final_result;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  always_comb begin
    raw = (state_q == HELD) ? hold_q : mem_if.data_sram_rdata;
    case (addr_lo_q)
      2'd0:    byte_lane = raw[7:0];
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      default: byte_lane = raw[31:24];
    endcase
    half_lane = addr_lo_q[1] ? raw[31:16] : raw[15:0];
    sext      = ~ld_type_q[2];
    case (ld_type_q[1:0])
      2'd0:    ld_data = {{24{sext & byte_lane[7]}}, byte_lane};
      2'd1:    ld_data = {{16{sext & half_lane[15]}}, half_lane};
      default: ld_data = raw;
    endcase
    final_result = res_from_mem_q ? ld_data : alu_result_q;
  end

  assign mem_if.mem_allowin     = mem_allowin;
  assign mem_if.mem_to_wb_valid = mem_valid_q;
  assign mem_if.mem_to_wb_bus   = {pc_q, rf_we_q & mem_valid_q, rf_waddr_q, final_result};
  assign mem_if.mem_to_id_bus   = {rf_we_q & mem_valid_q, rf_waddr_q, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/reset scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus_if();
  mem_stage dut (.clk(clk), .reset(reset), .mem_if(bus_if.slave));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic        rfm;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [3:0]  typ;
  } instr_t;

  function automatic instr_t rand_instr();
    instr_t r;
    r.pc   = $urandom;
    r.rfm  = 1'($urandom_range(0, 1));
    r.we   = 1'($urandom_range(0, 1));
    r.wa   = 5'($urandom);
    r.alu  = $urandom;
    r.addr = $urandom;
    r.typ  = 4'($urandom);
    return r;
  endfunction

  function automatic instr_t mk(logic [31:0] pc, logic rfm, logic we, logic [4:0] wa,
                                logic [31:0] alu, logic [31:0] addr, logic [3:0] typ);
    instr_t r;
    r.pc = pc; r.rfm = rfm; r.we = we; r.wa = wa; r.alu = alu; r.addr = addr; r.typ = typ;
    return r;
  endfunction

  function automatic logic [138:0] pack(instr_t i);
    logic [31:0] rkd;
    rkd = $urandom;
    return {i.pc, i.rfm, i.we, i.wa, i.alu, rkd, i.addr, i.typ};
  endfunction

  // Reference load result computed with shifts/masks from the load rules.
  function automatic logic [31:0] ref_final(instr_t i, logic [31:0] word);
    logic [31:0] v;
    int sh;
    if (!i.rfm) return i.alu;
    if (i.typ[1:0] == 2'd0) begin
      sh = 8 * int'(i.addr[1:0]);
      v  = (word >> sh) & 32'h0000_00FF;
      if (!i.typ[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (i.typ[1:0] == 2'd1) begin
      sh = i.addr[1] ? 16 : 0;
      v  = (word >> sh) & 32'h0000_FFFF;
      if (!i.typ[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [69:0] ref_wb(instr_t i, logic [31:0] word);
    return {i.pc, i.we, i.wa, ref_final(i, word)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, instr_t i);
    bus_if.ex_to_mem_valid = v;
    bus_if.ex_to_mem_bus   = pack(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, rand_instr());
    bus_if.wb_allowin      = 1'b0;
    bus_if.data_sram_rdata = $urandom;
    tick(); tick();
    #1;
    n_cmp++; if (bus_if.mem_allowin !== 1'b1) begin n_err++;
      $display("FAIL reset_allowin: got %b expected 1", bus_if.mem_allowin); end
    n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid: got %b expected 0", bus_if.mem_to_wb_valid); end
    n_cmp++; if (bus_if.mem_to_wb_bus !== 70'd0) begin n_err++;
      $display("FAIL reset_wb_bus: got %h expected 0", bus_if.mem_to_wb_bus); end
    n_cmp++; if (bus_if.mem_to_id_bus !== 38'd0) begin n_err++;
      $display("FAIL reset_id_bus: got %h expected 0", bus_if.mem_to_id_bus); end
    bus_if.ex_to_mem_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ld_b();
    instr_t i;
    i = mk(32'h0000_1000, 1'b1, 1'b1, 5'd3, 32'h1111_2222, 32'h0000_0103, 4'b0000);
    bus_if.wb_allowin = 1'b1;
    drive(1'b1, i);
    tick();
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = 32'h80FF_1234;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b1) begin n_err++;
      $display("FAIL ldb_valid: got %b expected 1", bus_if.mem_to_wb_valid); end
    n_cmp++; if (bus_if.mem_to_wb_bus !== {32'h0000_1000, 1'b1, 5'd3, 32'hFFFF_FF80}) begin n_err++;
      $display("FAIL ldb_result: got %h expected %h", bus_if.mem_to_wb_bus,
               {32'h0000_1000, 1'b1, 5'd3, 32'hFFFF_FF80}); end
    tick();
    n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL ldb_one_cycle: got %b expected 0", bus_if.mem_to_wb_valid); end
  endtask

  task automatic test_ld_h();
    logic [3:0]  typs [2] = '{4'b0101, 4'b0001};
    logic [31:0] exps [2] = '{32'h0000_8001, 32'hFFFF_8001};
    instr_t i;
    bus_if.wb_allowin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i = mk($urandom, 1'b1, 1'b1, 5'd7, $urandom, 32'h0000_2003 - 32'(k), typs[k]);
      drive(1'b1, i);
      tick();
      bus_if.ex_to_mem_valid = 1'b0;
      bus_if.data_sram_rdata = 32'h8001_0000;
      #1;
      n_cmp++; if (bus_if.mem_to_wb_bus[31:0] !== exps[k]) begin n_err++;
        $display("FAIL ldh_%0d: got %h expected %h", k, bus_if.mem_to_wb_bus[31:0], exps[k]); end
      tick();
    end
  endtask

  task automatic test_stall();
    instr_t i, j;
    i = mk(32'h0000_3000, 1'b1, 1'b1, 5'd9, 32'h0, 32'h0000_0040, 4'b0010);
    j = mk(32'h0000_3004, 1'b1, 1'b1, 5'd10, 32'h0, 32'h0000_0044, 4'b0010);
    bus_if.wb_allowin = 1'b1;
    drive(1'b1, i);
    tick();
    drive(1'b1, j);
    bus_if.wb_allowin      = 1'b0;
    bus_if.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_bus[31:0] !== 32'hDEAD_BEEF || bus_if.mem_allowin !== 1'b0) begin n_err++;
      $display("FAIL stall_c1: got %h/%b expected deadbeef/0", bus_if.mem_to_wb_bus[31:0], bus_if.mem_allowin); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      bus_if.data_sram_rdata = 32'h0;
      if (c == 4) bus_if.wb_allowin = 1'b1;
      #1;
      n_cmp++; if (bus_if.mem_to_wb_bus !== ref_wb(i, 32'hDEAD_BEEF) || bus_if.mem_to_wb_valid !== 1'b1) begin n_err++;
        $display("FAIL stall_c%0d_data: got %h expected %h", c, bus_if.mem_to_wb_bus, ref_wb(i, 32'hDEAD_BEEF)); end
      n_cmp++; if (bus_if.mem_allowin !== (c == 4)) begin n_err++;
        $display("FAIL stall_c%0d_allowin: got %b expected %b", c, bus_if.mem_allowin, c == 4); end
    end
    tick();
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_bus !== ref_wb(j, 32'hCAFE_F00D) || bus_if.mem_to_wb_valid !== 1'b1) begin n_err++;
      $display("FAIL swap_fresh: got %h expected %h", bus_if.mem_to_wb_bus, ref_wb(j, 32'hCAFE_F00D)); end
    tick();
  endtask

  task automatic test_alu_fwd();
    instr_t i;
    i = mk(32'h0000_4000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, $urandom, 4'($urandom));
    bus_if.wb_allowin = 1'b1;
    drive(1'b1, i);
    tick();
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = $urandom;
    #1;
    n_cmp++; if (bus_if.mem_to_id_bus !== {1'b1, 5'd5, 32'h1234_5678}) begin n_err++;
      $display("FAIL fwd_alu: got %h expected %h", bus_if.mem_to_id_bus, {1'b1, 5'd5, 32'h1234_5678}); end
    tick();
    n_cmp++; if (bus_if.mem_to_id_bus[37] !== 1'b0 || bus_if.mem_to_wb_bus[37] !== 1'b0) begin n_err++;
      $display("FAIL fwd_bubble_we: got %b/%b expected 0/0", bus_if.mem_to_id_bus[37], bus_if.mem_to_wb_bus[37]); end
  endtask

  task automatic test_back_to_back();
    instr_t q[$];
    instr_t i, e;
    logic [31:0] w;
    bus_if.wb_allowin = 1'b1;
    for (int c = 0; c < 24; c++) begin
      i = rand_instr();
      drive(1'b1, i);
      q.push_back(i);
      tick();
      w = $urandom;
      bus_if.data_sram_rdata = w;
      #1;
      e = q.pop_front();
      n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_to_wb_bus !== ref_wb(e, w)) begin n_err++;
        $display("FAIL b2b_%0d: got %b %h expected 1 %h", c, bus_if.mem_to_wb_valid, bus_if.mem_to_wb_bus, ref_wb(e, w)); end
      n_cmp++; if (bus_if.mem_to_id_bus !== {e.we, e.wa, ref_final(e, w)}) begin n_err++;
        $display("FAIL b2b_id_%0d: got %h expected %h", c, bus_if.mem_to_id_bus, {e.we, e.wa, ref_final(e, w)}); end
    end
    bus_if.ex_to_mem_valid = 1'b0;
    tick();
    n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL b2b_drain: got %b expected 0", bus_if.mem_to_wb_valid); end
  endtask

  // Model: an instruction sees the SRAM word of its first MEM cycle for its whole stay.
  task automatic test_random();
    instr_t cur, nxt;
    logic cur_valid = 1'b0;
    logic fresh = 1'b0;
    logic [31:0] first_word = '0;
    logic acc;
    for (int c = 0; c < 400; c++) begin
      nxt = rand_instr();
      drive(1'($urandom_range(0, 3) != 0), nxt);
      bus_if.wb_allowin      = ($urandom_range(0, 2) != 0);
      bus_if.data_sram_rdata = $urandom;
      if (cur_valid && fresh) first_word = bus_if.data_sram_rdata;
      acc = !cur_valid || bus_if.wb_allowin;
      #1;
      n_cmp++; if (bus_if.mem_allowin !== acc || bus_if.mem_to_wb_valid !== cur_valid) begin n_err++;
        $display("FAIL rnd_ctl_%0d: got %b%b expected %b%b", c, bus_if.mem_allowin, bus_if.mem_to_wb_valid, acc, cur_valid); end
      if (cur_valid) begin
        n_cmp++; if (bus_if.mem_to_wb_bus !== ref_wb(cur, first_word)) begin n_err++;
          $display("FAIL rnd_data_%0d: got %h expected %h", c, bus_if.mem_to_wb_bus, ref_wb(cur, first_word)); end
      end else begin
        n_cmp++; if (bus_if.mem_to_id_bus[37] !== 1'b0) begin n_err++;
          $display("FAIL rnd_we_%0d: got %b expected 0", c, bus_if.mem_to_id_bus[37]); end
      end
      fresh = 1'b0;
      if (acc) begin
        cur_valid = bus_if.ex_to_mem_valid;
        if (cur_valid) begin cur = nxt; fresh = 1'b1; end
      end
      tick();
    end
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.wb_allowin      = 1'b1;
    tick();
  endtask

  task automatic test_reset_held();
    instr_t i, j;
    i = mk(32'h0000_5000, 1'b1, 1'b1, 5'd12, 32'h0, 32'h0000_0080, 4'b0010);
    j = mk(32'h0000_6000, 1'b1, 1'b1, 5'd13, 32'h0, 32'h0000_0090, 4'b0010);
    bus_if.wb_allowin = 1'b0;
    drive(1'b1, i);
    tick();
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = 32'hAAAA_5555;
    tick();
    bus_if.data_sram_rdata = 32'h0;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_bus[31:0] !== 32'hAAAA_5555) begin n_err++;
      $display("FAIL rst_held_pre: got %h expected aaaa5555", bus_if.mem_to_wb_bus[31:0]); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_valid !== 1'b0 || bus_if.mem_allowin !== 1'b1 || bus_if.mem_to_id_bus !== 38'd0) begin n_err++;
      $display("FAIL rst_async: got %b %b %h expected 0 1 0", bus_if.mem_to_wb_valid, bus_if.mem_allowin, bus_if.mem_to_id_bus); end
    tick();
    reset = 1'b0;
    bus_if.wb_allowin = 1'b1;
    drive(1'b1, j);
    tick();
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = 32'h1234_5678;
    #1;
    n_cmp++; if (bus_if.mem_to_wb_bus !== ref_wb(j, 32'h1234_5678) || bus_if.mem_to_wb_valid !== 1'b1) begin n_err++;
      $display("FAIL rst_fresh: got %h expected %h", bus_if.mem_to_wb_bus, ref_wb(j, 32'h1234_5678)); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.ex_to_mem_bus   = '0;
    bus_if.wb_allowin      = 1'b1;
    bus_if.data_sram_rdata = '0;
    test_reset();
    test_ld_b();
    test_ld_h();
    test_stall();
    test_alu_fwd();
    test_back_to_back();
    test_random();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
